// File: rtl/sprite_blit_if.sv
// Bundles the signals a sprite blitter uses to talk to the draw queue, the sprite
// texel storage and the framebuffer write port.
interface sprite_blit_if #(
  parameter int SPRITE_NUM = 16,
  parameter int SPRITE_W   = 32,
  parameter int SCREEN_W   = 320,
  parameter int SCREEN_H   = 240
);
  localparam int SLW = $clog2(SPRITE_NUM);
  localparam int TAW = $clog2(SPRITE_W * SPRITE_W);
  localparam int FAW = $clog2(SCREEN_W * SCREEN_H);

  logic           q_is_empty;
  logic           q_dequeue;
  logic [7:0]     q_sprite_id;
  logic [15:0]    q_sprite_x;
  logic [15:0]    q_sprite_y;
  logic [7:0]     q_sprite_scale;

  logic [SLW-1:0] st_select;
  logic [TAW-1:0] st_addr;
  logic [3:0]     st_data;

  logic           fb_w_en;
  logic [FAW-1:0] fb_w_addr;
  logic [3:0]     fb_w_data;
  logic           fb_w_ready;

  modport master (
    input  q_is_empty, q_sprite_id, q_sprite_x, q_sprite_y, q_sprite_scale,
    input  st_data, fb_w_ready,
    output q_dequeue, st_select, st_addr, fb_w_en, fb_w_addr, fb_w_data
  );

  modport slave (
    output q_is_empty, q_sprite_id, q_sprite_x, q_sprite_y, q_sprite_scale,
    output st_data, fb_w_ready,
    input  q_dequeue, st_select, st_addr, fb_w_en, fb_w_addr, fb_w_data
  );
endinterface

// File: rtl/sprite_blit_scheduler.sv
// Pops draw-queue entries and walks every scaled output pixel of the sprite, issuing
// texel reads and clipped, transparency-filtered framebuffer writes.
//
// state | meaning
// IDLE  | waiting for a queued sprite
// LOAD  | latch head entry, pop queue, reject bad ids
// WALK  | issue one output offset per unstalled cycle
// DRAIN | let the last pixel leave stage 1, then pulse sprite_done
module sprite_blit_scheduler #(
  parameter int SPRITE_NUM = 16,
  parameter int SPRITE_W   = 32,
  parameter int SCREEN_W   = 320,
  parameter int SCREEN_H   = 240,
  parameter int MAX_SCALE  = 4
) (
  input  logic          clock,
  input  logic          reset,
  sprite_blit_if.master bus,
  output logic          busy,
  output logic          sprite_done,
  output logic          bad_id
);
  localparam int UW  = $clog2(SPRITE_W);
  localparam int SLW = $clog2(SPRITE_NUM);
  localparam int SCW = $clog2(MAX_SCALE + 1);
  localparam int OW  = $clog2(SPRITE_W * MAX_SCALE);
  localparam int FAW = $clog2(SCREEN_W * SCREEN_H);

  localparam logic [UW-1:0] U_LAST = UW'(SPRITE_W - 1);
  localparam logic [16:0]   SCR_W  = 17'(SCREEN_W);
  localparam logic [16:0]   SCR_H  = 17'(SCREEN_H);
  localparam logic [7:0]    NUM_L  = 8'(SPRITE_NUM);
  localparam logic [7:0]    MAXS_L = 8'(MAX_SCALE);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WALK, S_DRAIN} state_t;

  state_t         state_q, state_d;
  logic [SLW-1:0] slot_q, slot_d;
  logic [15:0]    x_q, x_d, y_q, y_d;
  logic [SCW-1:0] s_q, s_d, rx_q, rx_d, ry_q, ry_d;
  logic [OW-1:0]  ox_q, ox_d, oy_q, oy_d;
  logic [UW-1:0]  u_q, u_d, v_q, v_d;
  logic           s1_valid_q, s1_valid_d;
  logic [16:0]    px_q, px_d, py_q, py_d;
  logic           held_q, held_d;
  logic [3:0]     hold_data_q, hold_data_d;
  logic           sprite_done_q, sprite_done_d;

  logic           dequeue_c, bad_id_c;
  logic [3:0]     pix;
  logic           wr, stall, row_end, col_end;
  logic [SCW-1:0] s_eff, s_last;
  logic [FAW-1:0] fb_addr_full;

  // A stalled pixel keeps its own copy of the texel so the write cannot depend on
  // what storage returns while the read address sits on the next offset.
  assign pix          = held_q ? hold_data_q : bus.st_data;
  assign wr           = s1_valid_q && (pix != 4'd0) && (px_q < SCR_W) && (py_q < SCR_H);
  assign stall        = wr && !bus.fb_w_ready;
  assign s_last       = s_q - SCW'(1);
  assign row_end      = (u_q == U_LAST) && (rx_q == s_last);
  assign col_end      = (v_q == U_LAST) && (ry_q == s_last);
  assign fb_addr_full = FAW'(py_q) * FAW'(SCREEN_W) + FAW'(px_q);

  always_comb begin
    if (bus.q_sprite_scale == 8'd0)        s_eff = SCW'(1);
    else if (bus.q_sprite_scale > MAXS_L)  s_eff = SCW'(MAX_SCALE);
    else                                   s_eff = bus.q_sprite_scale[SCW-1:0];
  end

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    x_d           = x_q;
    y_d           = y_q;
    s_d           = s_q;
    rx_d          = rx_q;
    ry_d          = ry_q;
    ox_d          = ox_q;
    oy_d          = oy_q;
    u_d           = u_q;
    v_d           = v_q;
    px_d          = px_q;
    py_d          = py_q;
    s1_valid_d    = stall ? s1_valid_q : 1'b0;
    held_d        = stall;
    hold_data_d   = stall ? pix : hold_data_q;
    sprite_done_d = 1'b0;
    dequeue_c     = 1'b0;
    bad_id_c      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!bus.q_is_empty) state_d = S_LOAD;
      end
      S_LOAD: begin
        dequeue_c = !bus.q_is_empty;
        slot_d    = bus.q_sprite_id[SLW-1:0];
        x_d       = bus.q_sprite_x;
        y_d       = bus.q_sprite_y;
        s_d       = s_eff;
        rx_d      = '0;
        ry_d      = '0;
        ox_d      = '0;
        oy_d      = '0;
        u_d       = '0;
        v_d       = '0;
        if (bus.q_sprite_id >= NUM_L) begin
          bad_id_c = 1'b1;
          state_d  = S_IDLE;
        end else begin
          state_d  = S_WALK;
        end
      end
      S_WALK: begin
        if (!stall) begin
          s1_valid_d = 1'b1;
          px_d       = 17'(x_q) + 17'(ox_q);
          py_d       = 17'(y_q) + 17'(oy_q);
          // Replicate counters stand in for the divide: u/v step once every s_eff offsets.
          if (row_end) begin
            ox_d = '0;
            u_d  = '0;
            rx_d = '0;
            oy_d = oy_q + OW'(1);
            if (ry_q == s_last) begin
              ry_d = '0;
              v_d  = v_q + UW'(1);
            end else begin
              ry_d = ry_q + SCW'(1);
            end
            if (col_end) state_d = S_DRAIN;
          end else begin
            ox_d = ox_q + OW'(1);
            if (rx_q == s_last) begin
              rx_d = '0;
              u_d  = u_q + UW'(1);
            end else begin
              rx_d = rx_q + SCW'(1);
            end
          end
        end
      end
      S_DRAIN: begin
        if (!s1_valid_q) begin
          sprite_done_d = 1'b1;
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      slot_q        <= '0;
      x_q           <= '0;
      y_q           <= '0;
      s_q           <= '0;
      rx_q          <= '0;
      ry_q          <= '0;
      ox_q          <= '0;
      oy_q          <= '0;
      u_q           <= '0;
      v_q           <= '0;
      px_q          <= '0;
      py_q          <= '0;
      s1_valid_q    <= 1'b0;
      held_q        <= 1'b0;
      hold_data_q   <= '0;
      sprite_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      x_q           <= x_d;
      y_q           <= y_d;
      s_q           <= s_d;
      rx_q          <= rx_d;
      ry_q          <= ry_d;
      ox_q          <= ox_d;
      oy_q          <= oy_d;
      u_q           <= u_d;
      v_q           <= v_d;
      px_q          <= px_d;
      py_q          <= py_d;
      s1_valid_q    <= s1_valid_d;
      held_q        <= held_d;
      hold_data_q   <= hold_data_d;
      sprite_done_q <= sprite_done_d;
    end
  end

  assign bus.q_dequeue = dequeue_c;
  assign bus.st_select = slot_q;
  assign bus.st_addr   = {v_q, u_q};
  assign bus.fb_w_en   = wr;
  assign bus.fb_w_addr = wr ? fb_addr_full : '0;
  assign bus.fb_w_data = wr ? pix : 4'd0;
  assign busy          = (state_q != S_IDLE);
  assign sprite_done   = sprite_done_q;
  assign bad_id        = bad_id_c;
endmodule

// File: tb/tb_sprite_blit_scheduler.sv
// Bench for sprite_blit_scheduler: queue/storage/framebuffer models, directed corner
// sprites plus random sprites, all writes compared against a pixel-walk reference.
module tb_sprite_blit_scheduler;
  typedef struct {int id; int x; int y; int scale;} ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, sprite_done, bad_id;
  always #5 clk = ~clk;

  sprite_blit_if #(.SPRITE_NUM(16), .SPRITE_W(32), .SCREEN_W(320), .SCREEN_H(240)) bus ();

  sprite_blit_scheduler #(
    .SPRITE_NUM(16), .SPRITE_W(32), .SCREEN_W(320), .SCREEN_H(240), .MAX_SCALE(4)
  ) dut (
    .clock(clk), .reset(rst), .bus(bus), .busy(busy), .sprite_done(sprite_done), .bad_id(bad_id)
  );

  logic [3:0] mem [16][1024];
  ent_t qf[$];
  int   acts[$];
  int   exp_q[$];
  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0, deq_cnt = 0, bad_cnt = 0, done_cnt = 0, load_cyc = 0, done_cyc = 0;
  int   ready_mode = 0;
  bit   pop_pend = 0, prev_stall = 0;
  int   prev_addr = 0, prev_data = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // storage: synchronous read, data one cycle after address
  always @(posedge clk) bus.st_data <= mem[bus.st_select][bus.st_addr];

  // queue head, pops and fb_w_ready are all driven just after the rising edge
  always @(posedge clk) begin
    ent_t d;
    cyc++;
    #1;
    if (pop_pend) begin
      pop_pend = 0;
      if (qf.size() > 0) d = qf.pop_front();
    end
    bus.q_is_empty = (qf.size() == 0);
    if (qf.size() > 0) begin
      bus.q_sprite_id    = 8'(qf[0].id);
      bus.q_sprite_x     = 16'(qf[0].x);
      bus.q_sprite_y     = 16'(qf[0].y);
      bus.q_sprite_scale = 8'(qf[0].scale);
    end else begin
      bus.q_sprite_id = 8'd0; bus.q_sprite_x = 16'd0; bus.q_sprite_y = 16'd0; bus.q_sprite_scale = 8'd0;
    end
    case (ready_mode)
      1:       bus.fb_w_ready = ($urandom_range(0, 3) != 0);
      2:       bus.fb_w_ready = 1'b0;
      default: bus.fb_w_ready = 1'b1;
    endcase
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (bus.q_dequeue) begin
        chk("deq_nonempty", bus.q_is_empty, 0);
        deq_cnt++; load_cyc = cyc; pop_pend = 1;
      end
      if (bad_id) bad_cnt++;
      if (sprite_done) begin done_cnt++; done_cyc = cyc; end
      if (prev_stall) begin
        chk("stall_en", bus.fb_w_en, 1);
        chk("stall_addr", bus.fb_w_addr, prev_addr);
        chk("stall_data", bus.fb_w_data, prev_data);
      end
      if (bus.fb_w_en && bus.fb_w_ready) acts.push_back(int'(bus.fb_w_addr) * 16 + int'(bus.fb_w_data));
      prev_stall = bus.fb_w_en && !bus.fb_w_ready;
      prev_addr  = int'(bus.fb_w_addr);
      prev_data  = int'(bus.fb_w_data);
    end
  end

  function automatic int eff_scale(int scale);
    if (scale == 0) return 1;
    if (scale > 4) return 4;
    return scale;
  endfunction

  // reference: every output offset maps to texel (ox/s, oy/s); keep opaque on-screen ones
  function automatic void build_exp(int id, int x, int y, int scale);
    int se, t, px, py;
    exp_q.delete();
    if (id >= 16) return;
    se = eff_scale(scale);
    for (int oy = 0; oy < 32 * se; oy++)
      for (int ox = 0; ox < 32 * se; ox++) begin
        t  = int'(mem[id][(oy / se) * 32 + ox / se]);
        px = x + ox;
        py = y + oy;
        if (t != 0 && px < 320 && py < 240) exp_q.push_back((py * 320 + px) * 16 + t);
      end
  endfunction

  task automatic run_sprite(input int id, input int x, input int y, input int scale,
                            input int mode, input int stall_at, output int a0, output int nw);
    int d0, b0, q0, n, lim, waited, nm, sa;
    ent_t e;
    d0 = done_cnt; b0 = bad_cnt; q0 = deq_cnt; a0 = acts.size(); sa = stall_at;
    n = (32 * eff_scale(scale)) * (32 * eff_scale(scale));
    e = '{id, x, y, scale};
    qf.push_back(e);
    ready_mode = mode;
    lim = n * 5 + 200;
    waited = 0;
    while (done_cnt == d0 && bad_cnt == b0 && waited < lim) begin
      @(negedge clk);
      waited++;
      if (sa >= 0 && acts.size() - a0 == sa) begin
        ready_mode = 2;
        repeat (5) @(negedge clk);
        ready_mode = mode;
        waited += 5;
        sa = -1;
      end
    end
    chk("finish_wait", (waited < lim), 1);
    repeat (4) @(negedge clk);
    ready_mode = 0;
    build_exp(id, x, y, scale);
    nw = acts.size() - a0;
    chk("n_writes", nw, exp_q.size());
    nm = 0;
    for (int i = 0; i < nw && i < exp_q.size(); i++)
      if (acts[a0 + i] != exp_q[i]) nm++;
    chk("write_seq", nm, 0);
    chk("deq_count", deq_cnt - q0, 1);
    chk("busy_after", busy, 0);
    if (id < 16) begin
      chk("done_pulses", done_cnt - d0, 1);
      chk("bad_pulses", bad_cnt - b0, 0);
      if (mode == 0 && stall_at < 0) chk("sprite_cycles", done_cyc - load_cyc, n + 3);
    end else begin
      chk("bad_pulses", bad_cnt - b0, 1);
      chk("done_pulses", done_cnt - d0, 0);
    end
  endtask

  initial begin
    int a0, nw, a1, nd;
    ent_t e;
    for (int s = 0; s < 16; s++)
      for (int i = 0; i < 1024; i++)
        mem[s][i] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
    for (int i = 0; i < 1024; i++) begin
      mem[2][i] = 4'd5;
      mem[4][i] = (((i % 32) + (i / 32)) % 2 == 1) ? 4'd7 : 4'd0;
    end
    mem[3][0] = 4'd9;

    // reset with a pending entry, then release
    e = '{2, 10, 20, 1};
    qf.push_back(e);
    repeat (3) @(negedge clk);
    chk("rst_deq", bus.q_dequeue, 0);
    chk("rst_fb_en", bus.fb_w_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", sprite_done, 0);
    chk("rst_bad", bad_id, 0);
    chk("rst_st_addr", bus.st_addr, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("deq_cycle1", bus.q_dequeue, 0);
    @(negedge clk);
    chk("deq_cycle2", bus.q_dequeue, 1);
    chk("busy_load", busy, 1);
    repeat (60) @(negedge clk);
    chk("busy_walk", busy, 1);
    chk("wr_before_rst", (acts.size() > 0), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_fb_en", bus.fb_w_en, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_fb_addr", bus.fb_w_addr, 0);
    chk("mid_rst_deq", bus.q_dequeue, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    a1 = acts.size();
    repeat (40) @(negedge clk);
    chk("wr_after_rst", acts.size() - a1, 0);
    chk("deq_total", deq_cnt, 1);

    run_sprite(2, 10, 20, 1, 0, -1, a0, nw);
    chk("solid_n", nw, 1024);
    if (nw > 0) begin
      chk("solid_first", acts[a0], 6410 * 16 + 5);
      chk("solid_last", acts[a0 + nw - 1], 16361 * 16 + 5);
    end

    run_sprite(4, 0, 0, 1, 0, -1, a0, nw);
    chk("checker_n", nw, 512);
    nd = 0;
    for (int i = 0; i < nw; i++) if (acts[a0 + i] % 16 != 7) nd++;
    chk("checker_data", nd, 0);

    run_sprite(3, 50, 60, 2, 0, -1, a0, nw);
    if (nw > 1) begin
      chk("scale2_w0", acts[a0], (60 * 320 + 50) * 16 + 9);
      chk("scale2_w1", acts[a0 + 1], (60 * 320 + 51) * 16 + 9);
    end

    run_sprite(2, 100, 100, 0, 0, -1, a0, nw);
    chk("scale0_n", nw, 1024);
    run_sprite(2, 0, 0, 200, 0, -1, a0, nw);
    chk("scale200_n", nw, 16384);
    run_sprite(2, 300, 230, 1, 0, -1, a0, nw);
    chk("clip_n", nw, 200);
    run_sprite(2, 65535, 0, 1, 0, -1, a0, nw);
    chk("offscreen_n", nw, 0);
    run_sprite(20, 0, 0, 1, 0, -1, a0, nw);
    run_sprite(2, 5, 5, 1, 0, 100, a0, nw);
    chk("stall_n", nw, 1024);

    for (int r = 0; r < 5; r++)
      run_sprite($urandom_range(0, 17), $urandom_range(0, 330), $urandom_range(0, 250),
                 $urandom_range(0, 2), $urandom_range(0, 1), -1, a0, nw);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sprite_blit_scheduler.md
Name: sprite_blit_scheduler

Overview:
- Drains the sprite draw queue one entry at a time and sequences the full pixel walk of each sprite.
- For each entry it issues read addresses to one sprite storage read port and emits clipped, transparency-filtered, integer-scaled pixel writes to the framebuffer write port.
- Sits between the SPI driver's queue/storage outputs and the framebuffer.
- It is the only sequencer of storage read port r0 and of framebuffer writes.

Parameters:
- SPRITE_NUM, 16: number of sprite slots in storage.
- SPRITE_W, 32: sprite width and height in pixels (square, power of two).
- SCREEN_W, 320: framebuffer width in pixels.
- SCREEN_H, 240: framebuffer height in pixels.
- MAX_SCALE, 4: largest integer scale factor honoured.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- q_is_empty  in  1  draw queue empty.
- q_dequeue  out  1  one-cycle pop of the queue head.
- q_sprite_id  in  8  head sprite id.
- q_sprite_x  in  16  head x position (unsigned, top-left corner).
- q_sprite_y  in  16  head y position (unsigned, top-left corner).
- q_sprite_scale  in  8  head scale.
- st_select  out  $clog2(SPRITE_NUM)  storage slot select.
- st_addr  out  $clog2(SPRITE_W*SPRITE_W)  texel address, v*SPRITE_W+u.
- st_data  in  4  texel; valid one cycle after st_addr/st_select.
- fb_w_en  out  1  framebuffer write strobe.
- fb_w_addr  out  $clog2(SCREEN_W*SCREEN_H)  address, py*SCREEN_W+px.
- fb_w_data  out  4  pixel colour.
- fb_w_ready  in  1  framebuffer accepts a write this cycle.
- busy  out  1  high outside IDLE.
- sprite_done  out  1  one-cycle pulse when a sprite finishes.
- bad_id  out  1  one-cycle pulse when an entry is dropped.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0. Reset mid-sprite aborts the sprite; the queue is not popped again.
- States:
  - IDLE: if !q_is_empty -> LOAD.
  - LOAD (1 cycle): latch id, x, y and s_eff; assert q_dequeue. If id >= SPRITE_NUM -> pulse bad_id, go to IDLE with no writes. Else -> WALK.
  - WALK: iterate output offsets (ox, oy), ox fastest, each 0..SPRITE_W*s_eff-1. Texel u = ox / s_eff, v = oy / s_eff. After the last offset is issued -> DRAIN.
  - DRAIN: wait until the pipeline is empty, pulse sprite_done -> IDLE.
- Scale: s_eff = 1 if scale==0; MAX_SCALE if scale>MAX_SCALE; else scale. Division is done with replicate counters, not a divider.
- Pipeline: stage 0 drives st_addr, px = x+ox, py = y+oy. Stage 1 samples st_data and drives fb_*.
  - Latency from an offset issue to its fb_w_en is 1 cycle.
  - One offset per cycle when not stalled.
- px and py are computed 17 bits wide (no wrap).
- Write rule: fb_w_en = stage1_valid && st_data != 0 && px < SCREEN_W && py < SCREEN_H. Colour 0 is transparent.
- Pixels that are clipped or transparent consume the cycle without a write.
- Stall: when fb_w_ready=0 and stage 1 holds a pending write, freeze both stages and hold st_addr/st_select. Storage re-presents the same data. fb_w_en, addr and data stay stable until ready.
- No stall is required when stage 1 has no write.
- Sprite cycles with no stalls: (SPRITE_W*s_eff)^2 + 3.
- q_dequeue is never asserted while q_is_empty=1.
- A new entry is not loaded before sprite_done.
- A queue entry arriving during WALK is ignored until IDLE.

Test Plan:
- Reset with a non-empty queue, release: q_dequeue pulses in the 2nd cycle after release, busy=1. Assert reset during WALK: all outputs 0 next edge, no further writes.
- Sprite id=2, x=10, y=20, scale=1, texels all 5: 1024 writes. First address 20*320+10=6410, last 51*320+41=16361. sprite_done 1027 cycles after LOAD.
- Checkerboard texels 0/7: exactly 512 writes, all data 7. Addresses skip the zero texels.
- id=3, scale=2, texel(0,0)=9: writes 9 at (x,y), (x+1,y), (x,y+1), (x+1,y+1). 4096 offsets walked. Scale 0 behaves as 1, scale 200 as 4.
- Clipping, x=300, y=230: only px<320 and py<240 written (20*10=200 writes for solid texels). x=65535 produces 0 writes and sprite_done still pulses.
- id=20: bad_id pulse, one q_dequeue, zero fb writes. Hold fb_w_ready=0 for 5 cycles mid-walk: the write is held stable and no pixel is lost or duplicated.
